rob_commit_unit: RTL

//  Retire (head-side) consumer of the reorder buffer: inspects the head entry, performs its architectural

---
 rtl/rob_pkg.sv | 43 ++++
 rtl/commit_mem_align.sv | 61 ++++++
 rtl/rob_commit_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: ROB entry layout, control-bit positions, encodings and commit state type.
// Revision: 1.0
`default_nettype none

package rob_pkg;

    // ROB entry field positions
    localparam int VALID_BIT  = 113;
    localparam int RD_LSB     = 108;
    localparam int EX_LSB     = 76;
    localparam int WD_LSB     = 44;
    localparam int PC4_LSB    = 0;

    // Control bits live at absolute entry positions [43:32]
    localparam int C_REG_WRITE = 32;
    localparam int C_MEM_WRITE = 33;
    localparam int C_BRANCH    = 34;
    localparam int C_SRC_LSB   = 35;
    localparam int C_MISPRED   = 37;
    localparam int C_F3_LSB    = 38;
    localparam int C_RSVD_LSB  = 41;

    localparam logic [1:0] RS_EX   = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STORE     = 3'd1,
        ST_LOAD_REQ  = 3'd2,
        ST_LOAD_WAIT = 3'd3,
        ST_FLUSH     = 3'd4
    } commit_state_t;

endpackage

`default_nettype wire

// File: rtl/commit_mem_align.sv
// commit_mem_align: byte-enable generation, store lane replication and load extract/extend.
// Revision: 1.0
`default_nettype none

module commit_mem_align
    import rob_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] store_wdata,
    output logic [XLEN-1:0] load_result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = load_data[7:0];
        case (addr_lo)
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            2'd3:    byte_sel = load_data[31:24];
            default: byte_sel = load_data[7:0];
        endcase
        // Misaligned halves ignore addr_lo[0]
        half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    end

    always_comb begin
        be          = 4'b1111;
        store_wdata = store_data;
        load_result = load_data;
        case (funct3[1:0])
            F3_B[1:0]: begin
                be          = 4'b0001 << addr_lo;
                store_wdata = {4{store_data[7:0]}};
                load_result = funct3[2] ? {24'b0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H[1:0]: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{store_data[15:0]}};
                load_result = funct3[2] ? {16'b0, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be          = 4'b1111;
                store_wdata = store_data;
                load_result = load_data;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order retire stage popping the ROB head and applying its side effect.
// Revision: 1.0
`default_nettype none

module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRY_W = 114,
    parameter int REG_W   = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ENTRY_W-1:0] head_entry,
    input  logic               head_valid,
    input  logic               rob_empty,
    output logic               head_pop,
    output logic               rf_we,
    output logic [REG_W-1:0]   rf_wa,
    output logic [XLEN-1:0]    rf_wd,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic [3:0]         dmem_be,
    input  logic               dmem_ready,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               flush,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [31:0]        instret
);

    commit_state_t state, state_nxt;

    logic [REG_W-1:0] lat_rd;
    logic [XLEN-1:0]  lat_addr;
    logic [XLEN-1:0]  lat_wd;
    logic [2:0]       lat_f3;
    logic [XLEN-1:0]  redirect_q;
    logic [31:0]      instret_q;
    logic             latch_entry;

    logic [REG_W-1:0] h_rd;
    logic [XLEN-1:0]  h_ex;
    logic [XLEN-1:0]  h_wd;
    logic [XLEN-1:0]  h_pc4;
    logic [1:0]       h_src;
    logic [2:0]       h_f3;
    logic             h_reg_write, h_mem_write, h_branch, h_mispred;
    logic             retirable;
    logic [2:0]       unused_ctrl;

    assign h_rd        = head_entry[RD_LSB +: REG_W];
    assign h_ex        = head_entry[EX_LSB +: XLEN];
    assign h_wd        = head_entry[WD_LSB +: XLEN];
    assign h_pc4       = head_entry[PC4_LSB +: XLEN];
    assign h_src       = head_entry[C_SRC_LSB +: 2];
    assign h_f3        = head_entry[C_F3_LSB +: 3];
    assign h_reg_write = head_entry[C_REG_WRITE];
    assign h_mem_write = head_entry[C_MEM_WRITE];
    assign h_branch    = head_entry[C_BRANCH];
    assign h_mispred   = head_entry[C_MISPRED];
    assign unused_ctrl = head_entry[C_RSVD_LSB +: 3];

    assign retirable = head_valid & ~rob_empty & head_entry[VALID_BIT];

    logic [3:0]      align_be;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;

    commit_mem_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3      (lat_f3),
        .addr_lo     (lat_addr[1:0]),
        .store_data  (lat_wd),
        .load_data   (dmem_rdata),
        .be          (align_be),
        .store_wdata (align_wdata),
        .load_result (align_load)
    );

    // Outputs are held at zero throughout reset, including combinational retires
    always_comb begin
        state_nxt   = state;
        head_pop    = 1'b0;
        rf_we       = 1'b0;
        rf_wa       = '0;
        rf_wd       = '0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        flush       = 1'b0;
        latch_entry = 1'b0;
        if (rstn) begin
            case (state)
                ST_IDLE: begin
                    if (retirable) begin
                        if (h_mem_write) begin
                            latch_entry = 1'b1;
                            state_nxt   = ST_STORE;
                        end else if (h_src == RS_LOAD) begin
                            latch_entry = 1'b1;
                            state_nxt   = ST_LOAD_REQ;
                        end else begin
                            head_pop = 1'b1;
                            rf_we    = h_reg_write && (h_rd != '0);
                            rf_wa    = h_rd;
                            rf_wd    = (h_src == RS_PC4) ? h_pc4 : h_ex;
                            if (h_branch && h_mispred) begin
                                state_nxt = ST_FLUSH;
                            end
                        end
                    end
                end
                ST_STORE: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (dmem_ready) begin
                        head_pop  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_LOAD_REQ: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        state_nxt = ST_LOAD_WAIT;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (dmem_rvalid) begin
                        head_pop  = 1'b1;
                        rf_we     = (lat_rd != '0);
                        rf_wa     = lat_rd;
                        rf_wd     = align_load;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign dmem_addr   = dmem_req ? {lat_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_be     = dmem_req ? align_be : 4'b0000;
    assign dmem_wdata  = dmem_we ? align_wdata : '0;
    assign redirect_pc = redirect_q;
    assign instret     = instret_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            lat_rd     <= '0;
            lat_addr   <= '0;
            lat_wd     <= '0;
            lat_f3     <= '0;
            redirect_q <= '0;
            instret_q  <= '0;
        end else begin
            state <= state_nxt;
            if (latch_entry) begin
                lat_rd   <= h_rd;
                lat_addr <= h_ex;
                lat_wd   <= h_wd;
                lat_f3   <= h_f3;
            end
            if (state == ST_IDLE && state_nxt == ST_FLUSH) begin
                redirect_q <= h_ex;
            end
            if (head_pop) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire
